i2d_id: RTL and testbench
=========================

I2D_ID -- requirements
Module: i2d_id

Interface
REQ-001 Parameter LOAD_INTERLOCK, default 1, meaning: 1 enables the load-use bubble; 0 disables hazard detection.
REQ-002 clk  input  1  the single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 if_ins  input  32  instruction from fetch; valid when if_busy=0.
REQ-005 if_pc  input  32  PC of if_ins.
REQ-006 if_busy  input  1  1 means no instruction is offered this cycle.
REQ-007 flush  input  1  redirect (set_pc) in progress; discard all held or issued instructions.
REQ-008 ex_stall  input  1  execute cannot accept; hold all id_* outputs.
REQ-009 if_en  output  1  fetch may advance.
REQ-010 id_valid  output  1  id_* outputs carry a real instruction.
REQ-011 id_pc  output  32  PC of the issued instruction.
REQ-012 id_op  output  6  opcode, ins[31:26].
REQ-013 id_rd, id_rs, id_rt  output  5 each  ins[25:21], ins[20:16], ins[15:11].
REQ-014 id_imm  output  32  ins[15:0], sign-extended.
REQ-015 id_imm26  output  26  ins[25:0].
REQ-016 id_we, id_load, id_store, id_jump  output  1 each  decoded class flags.

Function
REQ-017 Opcodes: NOP=6'h00, ADD=6'h01, LD=6'h10, ST=6'h11, JMP=6'h20; any other opcode decodes as NOP with id_valid=0.
REQ-018 Class flags: ADD: we, uses rs and rt. LD: we, load, uses rs. ST: store, uses rs and rt. JMP: jump, uses neither. NOP: none.
REQ-019 Latency: an accepted instruction appears on id_* one clock after acceptance.
REQ-020 States: RUN, HOLD (ex_stall=1), BUBBLE (load-use).
REQ-021 Skid buffer: one entry (ins, pc, full). It is the only means of retaining an instruction offered while if_en=0.
REQ-022 Source: the skid entry when full, otherwise the input (if_busy=0).
REQ-023 Per-cycle priority: flush > ex_stall > load-use > issue.
REQ-024 Flush: next edge sets id_valid=0, id_op=NOP, skid full=0 and load-tracking cleared, regardless of ex_stall.
REQ-025 ex_stall=1: id_* registers hold their values. An input offered while the skid is empty is captured into the skid.
REQ-026 Load-use: the previous issued instruction is a valid LD with rd!=0, and the source reads rs or rt equal to that rd. Then the next edge issues a bubble (id_valid=0, fields NOP) and the source moves to or stays in the skid.
REQ-027 After one bubble, load-tracking is cleared and the held instruction issues on the next edge.
REQ-028 Register 0 never creates a hazard.
REQ-029 if_en = ~rst & ~skid_full & ~ex_stall & ~hazard, combinational.
REQ-030 No valid source and no stall: id_valid=0 and id_op=NOP.
REQ-031 An instruction is neither duplicated nor dropped except by flush.

Reset
REQ-032 While rst=1: id_valid=0, id_pc=0, id_op=NOP, id_rd/rs/rt=0, id_imm=0, id_imm26=0, all flags 0, skid empty, load-tracking cleared, state RUN, if_en=0.
REQ-033 Reset asserted mid-stall or mid-bubble discards all held instructions.

Structure
REQ-034 Opcode constants and field bit positions live in the shared i2d_defines.v.
REQ-035 The combinational field and class decoder is a sub-module, i2d_id_dec; i2d_id holds the pipeline registers, skid, hazard logic and state.

Verification
REQ-036 Stream ADD (0x04221800) at pc 0x100, if_busy=0 -> next cycle id_valid=1, id_pc=0x100, id_op=0x01, id_rd=1, id_rs=2, id_rt=3, id_we=1.
REQ-037 LD r5 (pc 0x200), then ADD reading rs=5 (pc 0x204) -> LD issues; next cycle bubble with if_en=0; then ADD issues with id_pc=0x204.
REQ-038 LD r0 followed by ADD reading r0 -> no bubble; back-to-back issue.
REQ-039 ex_stall=1 for 3 cycles with input offered -> id_* unchanged, if_en=0, skid captures one instruction; after release, instructions issue in order with none lost.
REQ-040 flush=1 with skid full and ex_stall=1 -> next cycle id_valid=0, skid empty, if_en=1.
REQ-041 ST with imm 0x8000 -> id_imm=0xFFFF8000; opcode 6'h3F -> id_valid=0.

Source files
------------

// File: rtl/i2d_id_pkg.sv
// Shared definitions for the i2d decode stage: opcodes, instruction field
// positions, the decode-stage state encoding and the decoded field bundle.
package i2d_id_pkg;

  localparam logic [5:0] OP_NOP = 6'h00;
  localparam logic [5:0] OP_ADD = 6'h01;
  localparam logic [5:0] OP_LD  = 6'h10;
  localparam logic [5:0] OP_ST  = 6'h11;
  localparam logic [5:0] OP_JMP = 6'h20;

  localparam int OP_HI  = 31;
  localparam int OP_LO  = 26;
  localparam int RD_HI  = 25;
  localparam int RD_LO  = 21;
  localparam int RS_HI  = 20;
  localparam int RS_LO  = 16;
  localparam int RT_HI  = 15;
  localparam int RT_LO  = 11;
  localparam int IMM_HI = 15;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HOLD   = 2'd1,
    ST_BUBBLE = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [5:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] imm;
    logic [25:0] imm26;
    logic        we;
    logic        load;
    logic        store;
    logic        jump;
  } id_fields_t;

endpackage

// File: rtl/i2d_id_dec.sv
// Combinational field and class decoder. Unknown opcodes yield an all-zero
// (NOP) bundle with o_known=0 and read no registers.
module i2d_id_dec
  import i2d_id_pkg::*;
(
  input  logic [31:0] i_ins,
  input  logic [31:0] i_pc,
  output id_fields_t  o_fields,
  output logic        o_known,
  output logic        o_usesRs,
  output logic        o_usesRt
);

  logic [5:0] w_op;

  assign w_op = i_ins[OP_HI:OP_LO];

  always_comb begin
    o_fields = '0;
    o_known  = 1'b0;
    o_usesRs = 1'b0;
    o_usesRt = 1'b0;
    case (w_op)
      OP_NOP: o_known = 1'b1;
      OP_ADD: begin
        o_known     = 1'b1;
        o_fields.we = 1'b1;
        o_usesRs    = 1'b1;
        o_usesRt    = 1'b1;
      end
      OP_LD: begin
        o_known       = 1'b1;
        o_fields.we   = 1'b1;
        o_fields.load = 1'b1;
        o_usesRs      = 1'b1;
      end
      OP_ST: begin
        o_known        = 1'b1;
        o_fields.store = 1'b1;
        o_usesRs       = 1'b1;
        o_usesRt       = 1'b1;
      end
      OP_JMP: begin
        o_known       = 1'b1;
        o_fields.jump = 1'b1;
      end
      default: o_known = 1'b0;
    endcase
    if (o_known) begin
      o_fields.pc    = i_pc;
      o_fields.op    = w_op;
      o_fields.rd    = i_ins[RD_HI:RD_LO];
      o_fields.rs    = i_ins[RS_HI:RS_LO];
      o_fields.rt    = i_ins[RT_HI:RT_LO];
      o_fields.imm   = {{16{i_ins[IMM_HI]}}, i_ins[IMM_HI:0]};
      o_fields.imm26 = i_ins[RD_HI:0];
    end
  end

endmodule

// File: rtl/i2d_id.sv
// Instruction decode stage: id_* pipeline registers, one-entry skid buffer,
// load-use interlock and the RUN/HOLD/BUBBLE control state.
module i2d_id
  import i2d_id_pkg::*;
#(
  parameter bit LOAD_INTERLOCK = 1'b1
)
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_ins,
  input  logic [31:0] if_pc,
  input  logic        if_busy,
  input  logic        flush,
  input  logic        ex_stall,
  output logic        if_en,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [5:0]  id_op,
  output logic [4:0]  id_rd,
  output logic [4:0]  id_rs,
  output logic [4:0]  id_rt,
  output logic [31:0] id_imm,
  output logic [25:0] id_imm26,
  output logic        id_we,
  output logic        id_load,
  output logic        id_store,
  output logic        id_jump
);

  state_t     r_state, w_stateNext;
  id_fields_t r_id, w_dec;
  logic       r_idValid, r_skidFull, r_ldValid;
  logic [31:0] r_skidIns, r_skidPc;
  logic [4:0] r_ldRd;
  logic       w_srcValid, w_known, w_usesRs, w_usesRt, w_hazard;
  logic       w_hold, w_bubble, w_issue, w_capture;
  logic [31:0] w_srcIns, w_srcPc;

  assign w_srcValid = r_skidFull | ~if_busy;
  assign w_srcIns   = r_skidFull ? r_skidIns : if_ins;
  assign w_srcPc    = r_skidFull ? r_skidPc  : if_pc;

  i2d_id_dec u_dec (
    .i_ins    (w_srcIns),
    .i_pc     (w_srcPc),
    .o_fields (w_dec),
    .o_known  (w_known),
    .o_usesRs (w_usesRs),
    .o_usesRt (w_usesRt)
  );

  // r_ldValid only ever holds a load with rd!=0; a bubble just taken never repeats.
  assign w_hazard = LOAD_INTERLOCK && r_ldValid && (r_state != ST_BUBBLE) && w_srcValid &&
                    ((w_usesRs && (w_dec.rs == r_ldRd)) || (w_usesRt && (w_dec.rt == r_ldRd)));

  assign if_en = ~rst & ~r_skidFull & ~ex_stall & ~w_hazard;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_RUN;
    else     r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = ST_RUN;
    if (flush)         w_stateNext = ST_RUN;
    else if (ex_stall) w_stateNext = ST_HOLD;
    else if (w_hazard) w_stateNext = ST_BUBBLE;
  end

  always_comb begin
    w_hold    = (w_stateNext == ST_HOLD);
    w_bubble  = (w_stateNext == ST_BUBBLE);
    w_issue   = (w_stateNext == ST_RUN) & ~flush;
    w_capture = ~r_skidFull & ~if_busy & (w_hold | w_bubble);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_id       <= '0;
      r_idValid  <= 1'b0;
      r_skidFull <= 1'b0;
      r_skidIns  <= '0;
      r_skidPc   <= '0;
      r_ldValid  <= 1'b0;
      r_ldRd     <= '0;
    end else if (flush) begin
      r_id       <= '0;
      r_idValid  <= 1'b0;
      r_skidFull <= 1'b0;
      r_ldValid  <= 1'b0;
    end else begin
      if (w_capture) begin
        r_skidIns  <= if_ins;
        r_skidPc   <= if_pc;
        r_skidFull <= 1'b1;
      end
      if (w_bubble) begin
        r_id      <= '0;
        r_idValid <= 1'b0;
        r_ldValid <= 1'b0;
      end else if (w_issue) begin
        r_skidFull <= 1'b0;
        if (w_srcValid) begin
          r_id      <= w_dec;
          r_idValid <= w_known;
          r_ldValid <= w_known & w_dec.load & (w_dec.rd != 5'd0);
          r_ldRd    <= w_dec.rd;
        end else begin
          r_id      <= '0;
          r_idValid <= 1'b0;
          r_ldValid <= 1'b0;
        end
      end
    end
  end

  assign id_valid = r_idValid;
  assign id_pc    = r_id.pc;
  assign id_op    = r_id.op;
  assign id_rd    = r_id.rd;
  assign id_rs    = r_id.rs;
  assign id_rt    = r_id.rt;
  assign id_imm   = r_id.imm;
  assign id_imm26 = r_id.imm26;
  assign id_we    = r_id.we;
  assign id_load  = r_id.load;
  assign id_store = r_id.store;
  assign id_jump  = r_id.jump;

endmodule

// File: tb/tb_i2d_id.sv
// Self-checking bench for i2d_id: queue-based reference model compared every
// negedge, plus directed vectors with hand-computed literal expectations.
module tb_i2d_id;

  localparam logic [5:0] M_NOP = 6'h00;
  localparam logic [5:0] M_ADD = 6'h01;
  localparam logic [5:0] M_LD  = 6'h10;
  localparam logic [5:0] M_ST  = 6'h11;
  localparam logic [5:0] M_JMP = 6'h20;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_ins, if_pc;
  logic        if_busy, flush, ex_stall;
  logic        if_en, id_valid;
  logic [31:0] id_pc, id_imm;
  logic [5:0]  id_op;
  logic [4:0]  id_rd, id_rs, id_rt;
  logic [25:0] id_imm26;
  logic        id_we, id_load, id_store, id_jump;

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  i2d_id #(.LOAD_INTERLOCK(1'b1)) dut (
    .clk(clk), .rst(rst), .if_ins(if_ins), .if_pc(if_pc), .if_busy(if_busy),
    .flush(flush), .ex_stall(ex_stall), .if_en(if_en), .id_valid(id_valid),
    .id_pc(id_pc), .id_op(id_op), .id_rd(id_rd), .id_rs(id_rs), .id_rt(id_rt),
    .id_imm(id_imm), .id_imm26(id_imm26), .id_we(id_we), .id_load(id_load),
    .id_store(id_store), .id_jump(id_jump)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic [5:0]  op;
    logic [4:0]  rd, rs, rt;
    logic [31:0] imm;
    logic [25:0] imm26;
    logic        we, load, store, jump;
  } exp_t;

  exp_t        mExp;
  logic [31:0] mSkidIns[$];
  logic [31:0] mSkidPc[$];

  function automatic exp_t zeroExp();
    exp_t e;
    e = '{default: '0};
    return e;
  endfunction

  function automatic exp_t decodeModel(input logic [31:0] ins, input logic [31:0] pc);
    exp_t e;
    logic [5:0] op;
    e  = zeroExp();
    op = ins[31:26];
    if (op == M_NOP || op == M_ADD || op == M_LD || op == M_ST || op == M_JMP) begin
      e.valid = 1'b1;
      e.pc    = pc;
      e.op    = op;
      e.rd    = ins[25:21];
      e.rs    = ins[20:16];
      e.rt    = ins[15:11];
      e.imm   = ins[15] ? (32'hFFFF0000 + {16'h0, ins[15:0]}) : {16'h0, ins[15:0]};
      e.imm26 = ins[25:0];
      e.we    = (op == M_ADD) || (op == M_LD);
      e.load  = (op == M_LD);
      e.store = (op == M_ST);
      e.jump  = (op == M_JMP);
    end
    return e;
  endfunction

  function automatic bit readsReg(input logic [31:0] ins, input logic [4:0] r);
    case (ins[31:26])
      M_ADD, M_ST: return (ins[20:16] == r) || (ins[15:11] == r);
      M_LD:        return (ins[20:16] == r);
      default:     return 1'b0;
    endcase
  endfunction

  // Load-use: what sits on id_* now is a real LD to a nonzero register.
  function automatic bit hazardNow();
    logic [31:0] src;
    if (!(mExp.valid && mExp.op == M_LD && mExp.rd != 5'd0)) return 1'b0;
    if (mSkidIns.size() > 0) src = mSkidIns[0];
    else if (!if_busy)       src = if_ins;
    else                     return 1'b0;
    return readsReg(src, mExp.rd);
  endfunction

  always @(posedge clk or posedge rst) begin : model
    bit hz;
    if (rst || flush) begin
      mExp = zeroExp();
      mSkidIns.delete();
      mSkidPc.delete();
    end else begin
      hz = hazardNow();
      if (ex_stall) begin
        if (mSkidIns.size() == 0 && !if_busy) begin
          mSkidIns.push_back(if_ins);
          mSkidPc.push_back(if_pc);
        end
      end else if (hz) begin
        mExp = zeroExp();
        if (mSkidIns.size() == 0) begin
          mSkidIns.push_back(if_ins);
          mSkidPc.push_back(if_pc);
        end
      end else if (mSkidIns.size() > 0) begin
        mExp = decodeModel(mSkidIns.pop_front(), mSkidPc.pop_front());
      end else if (!if_busy) begin
        mExp = decodeModel(if_ins, if_pc);
      end else begin
        mExp = zeroExp();
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      checkOutput("id_valid", {31'b0, id_valid}, {31'b0, mExp.valid});
      checkOutput("id_pc",    id_pc,             mExp.pc);
      checkOutput("id_op",    {26'b0, id_op},    {26'b0, mExp.op});
      checkOutput("id_rd",    {27'b0, id_rd},    {27'b0, mExp.rd});
      checkOutput("id_rs",    {27'b0, id_rs},    {27'b0, mExp.rs});
      checkOutput("id_rt",    {27'b0, id_rt},    {27'b0, mExp.rt});
      checkOutput("id_imm",   id_imm,            mExp.imm);
      checkOutput("id_imm26", {6'b0, id_imm26},  {6'b0, mExp.imm26});
      checkOutput("id_flags", {28'b0, id_we, id_load, id_store, id_jump},
                  {28'b0, mExp.we, mExp.load, mExp.store, mExp.jump});
      checkOutput("if_en", {31'b0, if_en},
                  {31'b0, (!rst && mSkidIns.size() == 0 && !ex_stall && !hazardNow())});
    end
  end

  task automatic setInputs(input logic [31:0] ins, input logic [31:0] pc,
                           input logic busy, input logic fl, input logic st);
    if_ins   = ins;
    if_pc    = pc;
    if_busy  = busy;
    flush    = fl;
    ex_stall = st;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] ins, input logic [31:0] pc,
                               input logic busy, input logic fl, input logic st);
    setInputs(ins, pc, busy, fl, st);
    tick();
  endtask

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs, input logic [15:0] lo);
    return {op, rd, rs, lo};
  endfunction

  function automatic logic [15:0] rtf(input logic [4:0] rt);
    return {rt, 11'b0};
  endfunction

  initial begin
    rst = 1'b1;
    setInputs(32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    tick();
    started = 1'b1;
    checkOutput("lit_reset_valid", {31'b0, id_valid}, 32'd0);
    checkOutput("lit_reset_pc",    id_pc, 32'd0);
    checkOutput("lit_reset_op",    {26'b0, id_op}, 32'd0);
    checkOutput("lit_reset_if_en", {31'b0, if_en}, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    checkOutput("lit_idle_if_en", {31'b0, if_en}, 32'd1);

    // Plain ADD streamed from fetch.
    applyStimulus(32'h04221800, 32'h100, 1'b0, 1'b0, 1'b0);
    checkOutput("lit_add_valid", {31'b0, id_valid}, 32'd1);
    checkOutput("lit_add_pc",    id_pc, 32'h100);
    checkOutput("lit_add_op",    {26'b0, id_op}, 32'h01);
    checkOutput("lit_add_regs",  {17'b0, id_rd, id_rs, id_rt}, {17'b0, 5'd1, 5'd2, 5'd3});
    checkOutput("lit_add_we",    {31'b0, id_we}, 32'd1);

    // LD r5 then dependent ADD: one bubble, then ADD from the skid.
    applyStimulus(mk(M_LD, 5'd5, 5'd1, 16'h0004), 32'h200, 1'b0, 1'b0, 1'b0);
    checkOutput("lit_ld_op",   {26'b0, id_op}, 32'h10);
    checkOutput("lit_ld_load", {31'b0, id_load}, 32'd1);
    setInputs(mk(M_ADD, 5'd6, 5'd5, rtf(5'd7)), 32'h204, 1'b0, 1'b0, 1'b0);
    #1;
    checkOutput("lit_lu_if_en", {31'b0, if_en}, 32'd0);
    tick();
    checkOutput("lit_bubble_valid", {31'b0, id_valid}, 32'd0);
    checkOutput("lit_bubble_op",    {26'b0, id_op}, 32'd0);
    checkOutput("lit_bubble_if_en", {31'b0, if_en}, 32'd0);
    applyStimulus(32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    checkOutput("lit_lu_after_valid", {31'b0, id_valid}, 32'd1);
    checkOutput("lit_lu_after_pc",    id_pc, 32'h204);

    // LD r0 never interlocks.
    applyStimulus(mk(M_LD, 5'd0, 5'd1, 16'h0), 32'h300, 1'b0, 1'b0, 1'b0);
    setInputs(mk(M_ADD, 5'd7, 5'd0, rtf(5'd0)), 32'h304, 1'b0, 1'b0, 1'b0);
    #1;
    checkOutput("lit_r0_if_en", {31'b0, if_en}, 32'd1);
    tick();
    checkOutput("lit_r0_pc", id_pc, 32'h304);

    // LD r4 then ST reading r4 through rt.
    applyStimulus(mk(M_LD, 5'd4, 5'd1, 16'h0), 32'h310, 1'b0, 1'b0, 1'b0);
    applyStimulus(mk(M_ST, 5'd0, 5'd1, rtf(5'd4)), 32'h314, 1'b0, 1'b0, 1'b0);
    checkOutput("lit_rt_bubble", {31'b0, id_valid}, 32'd0);
    applyStimulus(32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    checkOutput("lit_rt_after_pc", id_pc, 32'h314);

    // Three-cycle stall: hold, capture one into skid, release in order.
    applyStimulus(mk(M_ADD, 5'd1, 5'd2, rtf(5'd3)), 32'h400, 1'b0, 1'b0, 1'b0);
    applyStimulus(mk(M_ADD, 5'd2, 5'd3, rtf(5'd4)), 32'h404, 1'b0, 1'b0, 1'b1);
    checkOutput("lit_stall1_pc",   id_pc, 32'h400);
    checkOutput("lit_stall1_if_en", {31'b0, if_en}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(mk(M_ADD, 5'd3, 5'd4, 16'h0), 32'h408, 1'b0, 1'b0, 1'b1);
      checkOutput("lit_stall_hold_pc", id_pc, 32'h400);
    end
    applyStimulus(mk(M_ADD, 5'd3, 5'd4, 16'h0), 32'h408, 1'b0, 1'b0, 1'b0);
    checkOutput("lit_release1_pc", id_pc, 32'h404);
    applyStimulus(mk(M_ADD, 5'd3, 5'd4, 16'h0), 32'h408, 1'b0, 1'b0, 1'b0);
    checkOutput("lit_release2_pc", id_pc, 32'h408);

    // Load-use where the consumer waits in the skid across a stall.
    applyStimulus(mk(M_LD, 5'd9, 5'd1, 16'h0), 32'h420, 1'b0, 1'b0, 1'b0);
    applyStimulus(mk(M_ST, 5'd0, 5'd9, rtf(5'd2)), 32'h424, 1'b0, 1'b0, 1'b1);
    applyStimulus(32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    checkOutput("lit_skid_lu_bubble", {31'b0, id_valid}, 32'd0);
    applyStimulus(32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    checkOutput("lit_skid_lu_pc",    id_pc, 32'h424);
    checkOutput("lit_skid_lu_store", {31'b0, id_store}, 32'd1);

    // Flush beats stall and empties a full skid.
    applyStimulus(mk(M_ADD, 5'd1, 5'd1, 16'h0), 32'h500, 1'b0, 1'b0, 1'b1);
    applyStimulus(32'h0, 32'h0, 1'b1, 1'b1, 1'b1);
    checkOutput("lit_flush_valid", {31'b0, id_valid}, 32'd0);
    checkOutput("lit_flush_op",    {26'b0, id_op}, 32'd0);
    setInputs(32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    #1;
    checkOutput("lit_flush_if_en", {31'b0, if_en}, 32'd1);
    tick();
    checkOutput("lit_flush_empty", {31'b0, id_valid}, 32'd0);

    // Sign extension, unknown opcode, jump target.
    applyStimulus(mk(M_ST, 5'd1, 5'd2, 16'h8000), 32'h600, 1'b0, 1'b0, 1'b0);
    checkOutput("lit_st_imm", id_imm, 32'hFFFF8000);
    checkOutput("lit_st_rt",  {27'b0, id_rt}, 32'd16);
    applyStimulus(mk(6'h3F, 5'd1, 5'd2, 16'h0), 32'h604, 1'b0, 1'b0, 1'b0);
    checkOutput("lit_bad_valid", {31'b0, id_valid}, 32'd0);
    checkOutput("lit_bad_op",    {26'b0, id_op}, 32'd0);
    applyStimulus({M_JMP, 26'h2ABCDEF}, 32'h608, 1'b0, 1'b0, 1'b0);
    checkOutput("lit_jmp_imm26", {6'b0, id_imm26}, 32'h02ABCDEF);
    checkOutput("lit_jmp_flag",  {31'b0, id_jump}, 32'd1);

    // Reset while stalled with a full skid drops everything held.
    applyStimulus(mk(M_ADD, 5'd1, 5'd2, 16'h0), 32'h700, 1'b0, 1'b0, 1'b0);
    applyStimulus(mk(M_ADD, 5'd2, 5'd3, 16'h0), 32'h704, 1'b0, 1'b0, 1'b1);
    rst = 1'b1;
    #1;
    checkOutput("lit_rst_mid_valid", {31'b0, id_valid}, 32'd0);
    tick();
    rst = 1'b0;
    setInputs(32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("lit_rst_skid_gone", {31'b0, id_valid}, 32'd0);
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
